// File: rtl/craps_round_ctrl.sv
// Craps round sequencer: roll request, display window, dice latch, rule evaluation.
// Optional roll counter port enabled by defining ROLL_COUNT_EN.
module craps_round_ctrl #(
  parameter int unsigned ROLL_CYCLES = 8,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             roll_btn,
  input  logic [2:0]       dice1_in,
  input  logic [2:0]       dice2_in,
  output logic             disp_en,
  output logic [2:0]       dice1,
  output logic [2:0]       dice2,
  output logic [3:0]       point,
  output logic             win,
  output logic             lose,
`ifdef ROLL_COUNT_EN
  output logic [CNT_W-1:0] roll_count,
`endif
  output logic             busy
);

  typedef enum logic [2:0] {
    S_COMEOUT,
    S_POINT,
    S_ROLL,
    S_EVAL,
    S_WIN,
    S_LOSE
  } state_t;

  localparam logic [7:0] CNT_LOAD = 8'(ROLL_CYCLES - 1);

  if (ROLL_CYCLES == 0 || ROLL_CYCLES > 255 || CNT_W == 0) begin : g_param_err
    $error("craps_round_ctrl: illegal parameter value");
  end

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] dice1_q, dice1_d;
  logic [2:0] dice2_q, dice2_d;
  logic [3:0] point_q, point_d;
  logic       phase_pt_q, phase_pt_d;
  logic       roll_prev_q;
  logic       armed_q;
  logic       req;
  logic       dice_ok;
  logic [3:0] sum;

  // armed blocks a button still held from before reset release
  assign req = roll_btn & ~roll_prev_q & armed_q;

  assign dice_ok = (dice1_in != 3'd0) && (dice1_in != 3'd7) &&
                   (dice2_in != 3'd0) && (dice2_in != 3'd7);

  assign sum = {1'b0, dice1_q} + {1'b0, dice2_q};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dice1_d    = dice1_q;
    dice2_d    = dice2_q;
    point_d    = point_q;
    phase_pt_d = phase_pt_q;
    unique case (state_q)
      S_COMEOUT, S_POINT: begin
        if (req) begin
          state_d    = S_ROLL;
          cnt_d      = CNT_LOAD;
          phase_pt_d = (state_q == S_POINT);
        end
      end
      S_ROLL: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else if (dice_ok) begin
          dice1_d = dice1_in;
          dice2_d = dice2_in;
          state_d = S_EVAL;
        end
      end
      S_EVAL: begin
        if (!phase_pt_q) begin
          unique case (1'b1)
            (sum == 4'd7) || (sum == 4'd11):
              state_d = S_WIN;
            (sum == 4'd2) || (sum == 4'd3) || (sum == 4'd12):
              state_d = S_LOSE;
            default: begin
              point_d = sum;
              state_d = S_POINT;
            end
          endcase
        end else begin
          unique case (1'b1)
            sum == point_q: state_d = S_WIN;
            sum == 4'd7:    state_d = S_LOSE;
            default:        state_d = S_POINT;
          endcase
        end
      end
      S_WIN, S_LOSE: begin
        if (req) begin
          state_d    = S_ROLL;
          cnt_d      = CNT_LOAD;
          point_d    = 4'd0;
          phase_pt_d = 1'b0;
        end
      end
      default: state_d = S_COMEOUT;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_COMEOUT;
      cnt_q       <= 8'd0;
      dice1_q     <= 3'd0;
      dice2_q     <= 3'd0;
      point_q     <= 4'd0;
      phase_pt_q  <= 1'b0;
      roll_prev_q <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dice1_q     <= dice1_d;
      dice2_q     <= dice2_d;
      point_q     <= point_d;
      phase_pt_q  <= phase_pt_d;
      roll_prev_q <= roll_btn;
      armed_q     <= armed_q | ~roll_btn;
    end
  end

  assign disp_en = (state_q == S_ROLL);
  assign busy    = (state_q == S_ROLL) || (state_q == S_EVAL);
  assign win     = (state_q == S_WIN);
  assign lose    = (state_q == S_LOSE);
  assign dice1   = dice1_q;
  assign dice2   = dice2_q;
  assign point   = point_q;

`ifdef ROLL_COUNT_EN
  logic [CNT_W-1:0] rc_q;
  logic             new_game;

  assign new_game = req && ((state_q == S_WIN) || (state_q == S_LOSE));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rc_q <= '0;
    end else if (new_game) begin
      rc_q <= '0;
    end else if ((state_q == S_EVAL) && (rc_q != '1)) begin
      rc_q <= rc_q + CNT_W'(1);
    end
  end

  assign roll_count = rc_q;
`endif

endmodule

// File: tb/tb_craps_round_ctrl.sv
// Randomised bench for craps_round_ctrl with a game-rule reference model.
// Per-cycle output check against roll timeline plus literal scenario pins.
module tb_craps_round_ctrl;

  localparam int R = 8;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       roll_btn = 1'b0;
  logic [2:0] dice1_in = 3'd1;
  logic [2:0] dice2_in = 3'd1;
  logic       disp_en, win, lose, busy;
  logic [2:0] dice1, dice2;
  logic [3:0] point;
`ifdef ROLL_COUNT_EN
  logic [7:0] roll_count;
`endif

  craps_round_ctrl #(.ROLL_CYCLES(R), .CNT_W(8)) dut (
    .clock(clock),
    .resetn(resetn),
    .roll_btn(roll_btn),
    .dice1_in(dice1_in),
    .dice2_in(dice2_in),
    .disp_en(disp_en),
    .dice1(dice1),
    .dice2(dice2),
    .point(point),
    .win(win),
    .lose(lose),
`ifdef ROLL_COUNT_EN
    .roll_count(roll_count),
`endif
    .busy(busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // game model: result before the roll (pre_), after it (new_), shown during it (roll_)
  int p = -1;
  int x = 0;
  int pre_d1 = 0, pre_d2 = 0, pre_pt = 0, pre_w = 0, pre_l = 0, pre_c = 0;
  int new_d1 = 0, new_d2 = 0, new_pt = 0, new_w = 0, new_l = 0, new_c = 0;
  int roll_pt = 0, roll_c = 0;

  task automatic model_roll(input int a, input int b);
    int s;
    bit inpt;
    pre_d1 = new_d1; pre_d2 = new_d2; pre_pt = new_pt;
    pre_w  = new_w;  pre_l  = new_l;  pre_c  = new_c;
    s = a + b;
    inpt = (pre_pt != 0) && (pre_w == 0) && (pre_l == 0);
    roll_pt = inpt ? pre_pt : 0;
    roll_c  = (pre_w != 0 || pre_l != 0) ? 0 : pre_c;
    new_c   = (roll_c == 255) ? 255 : roll_c + 1;
    new_d1 = a;
    new_d2 = b;
    if (inpt) begin
      new_w  = (s == pre_pt) ? 1 : 0;
      new_l  = (new_w == 0 && s == 7) ? 1 : 0;
      new_pt = pre_pt;
    end else begin
      new_w  = (s == 7 || s == 11) ? 1 : 0;
      new_l  = (s == 2 || s == 3 || s == 12) ? 1 : 0;
      new_pt = (new_w != 0 || new_l != 0) ? 0 : s;
    end
  endtask

  task automatic model_reset();
    p = -1; x = 0;
    new_d1 = 0; new_d2 = 0; new_pt = 0; new_w = 0; new_l = 0; new_c = 0;
  endtask

  // one compare process: press edge p, ROLL for R+x cycles, one EVAL, then result
  always @(negedge clock) begin
    int e_en, e_bz, e_d1, e_d2, e_pt, e_w, e_l, e_c;
    if (p < 0 || cyc >= p + R + x + 1) begin
      e_en = 0; e_bz = 0; e_d1 = new_d1; e_d2 = new_d2;
      e_pt = new_pt; e_w = new_w; e_l = new_l; e_c = new_c;
    end else if (cyc < p) begin
      e_en = 0; e_bz = 0; e_d1 = pre_d1; e_d2 = pre_d2;
      e_pt = pre_pt; e_w = pre_w; e_l = pre_l; e_c = pre_c;
    end else if (cyc < p + R + x) begin
      e_en = 1; e_bz = 1; e_d1 = pre_d1; e_d2 = pre_d2;
      e_pt = roll_pt; e_w = 0; e_l = 0; e_c = roll_c;
    end else begin
      e_en = 0; e_bz = 1; e_d1 = new_d1; e_d2 = new_d2;
      e_pt = roll_pt; e_w = 0; e_l = 0; e_c = roll_c;
    end
    check("disp_en", 32'(disp_en), e_en);
    check("busy", 32'(busy), e_bz);
    check("dice1", 32'(dice1), e_d1);
    check("dice2", 32'(dice2), e_d2);
    check("point", 32'(point), e_pt);
    check("win", 32'(win), e_w);
    check("lose", 32'(lose), e_l);
`ifdef ROLL_COUNT_EN
    check("roll_count", 32'(roll_count), e_c);
`else
    if (e_c < 0) check("roll_count_model", 32'(e_c), 0);
`endif
  end

  function automatic logic [2:0] bad_die();
    return ($urandom_range(0, 1) == 0) ? 3'd0 : 3'd7;
  endfunction

  task automatic do_roll(input int a, input int b, input int xi,
                         input bit toggle, output int en_cnt);
    int rel, n;
    @(posedge clock); #2;
    model_roll(a, b);
    x = xi;
    p = cyc + 1;
    roll_btn = 1'b1;
    rel = $urandom_range(1, 3);
    en_cnt = 0;
    while (cyc < p + R + x + 1) begin
      @(posedge clock); #2;
      n = cyc;
      if (disp_en) en_cnt++;
      if (n >= p + rel - 1) roll_btn = 1'b0;
      if (toggle && n == p + 4) roll_btn = 1'b1;
      if (toggle && n == p + 5) roll_btn = 1'b0;
      if (n < p + R - 1) begin
        dice1_in = 3'($urandom_range(0, 7));
        dice2_in = 3'($urandom_range(0, 7));
      end else if (n < p + R - 1 + x) begin
        dice1_in = 3'($urandom_range(1, 6));
        dice2_in = 3'($urandom_range(1, 6));
        if ($urandom_range(0, 1) == 0) dice1_in = bad_die();
        else dice2_in = bad_die();
      end else begin
        dice1_in = 3'(a);
        dice2_in = 3'(b);
      end
    end
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clock);
    #2;
    check("rst_disp_en", 32'(disp_en), 0);
    check("rst_busy", 32'(busy), 0);
    resetn = 1'b1;
    @(posedge clock);

    do_roll(3, 4, 0, 0, n);
    check("natural_disp_cycles", n, 8);
    check("natural_win", 32'(win), 1);
    check("natural_d1", 32'(dice1), 3);
    check("natural_d2", 32'(dice2), 4);
    check("natural_point", 32'(point), 0);

    do_roll(6, 6, 0, 0, n);
    check("craps_lose", 32'(lose), 1);
    do_roll(1, 1, 0, 0, n);
    check("craps2_lose", 32'(lose), 1);

    do_roll(2, 2, 0, 0, n);
    check("pt_set", 32'(point), 4);
    do_roll(5, 3, 0, 0, n);
    check("pt_hold", 32'(point), 4);
    check("pt_hold_win", 32'(win), 0);
    do_roll(3, 1, 0, 0, n);
    check("pt_made_win", 32'(win), 1);
`ifdef ROLL_COUNT_EN
    check("pt_made_count", 32'(roll_count), 3);
`endif

    do_roll(4, 2, 0, 0, n);
    check("seven_pt", 32'(point), 6);
    do_roll(3, 4, 0, 0, n);
    check("seven_out_lose", 32'(lose), 1);
    check("seven_out_pt", 32'(point), 6);

    do_roll(1, 5, 3, 0, n);
    check("invalid_disp_cycles", n, 11);
    check("invalid_d1", 32'(dice1), 1);
    check("invalid_pt", 32'(point), 6);
    do_roll(2, 3, 0, 1, n);
    check("toggle_disp_cycles", n, 8);

    @(posedge clock); #2;
    model_roll(4, 4);
    x = 0;
    p = cyc + 1;
    roll_btn = 1'b1;
    repeat (4) @(posedge clock);
    #3;
    resetn = 1'b0;
    model_reset();
    #1;
    check("midrst_disp_en", 32'(disp_en), 0);
    check("midrst_dice1", 32'(dice1), 0);
    check("midrst_dice2", 32'(dice2), 0);
    check("midrst_point", 32'(point), 0);
    check("midrst_winlose", 32'({win, lose}), 0);
    repeat (2) @(posedge clock);
    #2;
    resetn = 1'b1;
    repeat (5) @(posedge clock);
    #2;
    check("held_no_roll", 32'(busy), 0);
    roll_btn = 1'b0;
    do_roll(5, 6, 0, 0, n);
    check("after_rst_win", 32'(win), 1);

    repeat (40) begin
      int xi;
      xi = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      do_roll($urandom_range(1, 6), $urandom_range(1, 6), xi,
              1'($urandom_range(0, 1)), n);
      check("rand_disp_cycles", n, R + xi);
    end

    repeat (3) @(posedge clock);
    #2;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/craps_round_ctrl.md
Name: craps_round_ctrl

Overview:
- Game-sequencing controller for the two-dice craps datapath.
- Accepts a roll request and pulses the display enable so the dice display animates for a fixed window.
- Latches both dice values, evaluates the come-out and point rules, and reports win, lose and point status.
- Sits between the player button / dice random source and the dice display; its dice1, dice2 and disp_en outputs drive the display's dice1, dice2 and clock_en inputs.

Parameters:
- ROLL_CYCLES, 8, cycles disp_en stays high per roll (animation window); legal range 1..255.
- CNT_W, 8, width of the optional roll counter.

Ports:
- clock  input  1  system clock, rising edge.
- resetn  input  1  asynchronous, active-low reset.
- roll_btn  input  1  roll request level; already synchronised to clock.
- dice1_in  input  3  first die from the random source; legal values 1..6.
- dice2_in  input  3  second die from the random source; legal values 1..6.
- disp_en  output  1  display clock enable; high during ROLL.
- dice1  output  3  latched first die.
- dice2  output  3  latched second die.
- point  output  4  current point; 0 when no point is set.
- win  output  1  high while in WIN.
- lose  output  1  high while in LOSE.
- busy  output  1  high in ROLL or EVAL.
- roll_count  output  CNT_W  rolls this game; only with ROLL_COUNT_EN.

Behaviour:
Reset (resetn=0, async):
- State=COMEOUT.
- disp_en=0, dice1=0, dice2=0, point=0, win=0, lose=0, busy=0, roll_count=0.
- Edge-detect register cleared to 0.

Roll request:
- Rising edge of roll_btn, registered: roll_prev<=roll_btn; req=roll_btn & ~roll_prev.
- Holding roll_btn high gives one request only.

States:
- COMEOUT: no point set. req -> ROLL.
- POINT: point set. req -> ROLL.
- ROLL:
  - disp_en=1 and busy=1.
  - Down-counter loaded with ROLL_CYCLES-1 on entry; decrements each cycle.
  - At count 0, dice1_in/dice2_in are sampled into dice1/dice2 and the state goes to EVAL.
  - disp_en is high for exactly ROLL_CYCLES cycles.
  - If either sampled die is 0 or 7, dice1/dice2 are not updated and ROLL continues one more cycle. Re-sampling repeats every cycle until both dice are valid.
- EVAL: one cycle, busy=1, disp_en=0. sum = dice1 + dice2, 4-bit, range 2..12.
  - From come-out:
    - sum 7 or 11 -> WIN.
    - sum 2, 3 or 12 -> LOSE.
    - otherwise point<=sum and -> POINT.
  - From point:
    - sum==point -> WIN.
    - sum==7 -> LOSE.
    - otherwise -> POINT, point unchanged.
  - A single registered flag `phase_pt` records which phase entered ROLL.
- WIN / LOSE:
  - win or lose held high; dice1, dice2 and point held for display.
  - req -> ROLL of a new game: point<=0, win/lose<=0, phase_pt<=0 on that transition.

Timing:
- req seen at edge t -> ROLL from t+1 to t+ROLL_CYCLES.
- EVAL at t+ROLL_CYCLES+1.
- Result state and outputs valid from t+ROLL_CYCLES+2.

Boundary conditions:
- req during ROLL or EVAL is ignored (dropped, not queued).
- Async reset mid-ROLL returns everything to reset values immediately, including disp_en=0.
- The ROLL counter is reloaded every entry; no leftover count carries between rolls.

Optional Feature:
Macro ROLL_COUNT_EN.
- Defined:
  - roll_count port exists.
  - It increments (saturating at all-ones) on every EVAL cycle.
  - It clears on reset and on the WIN/LOSE -> ROLL new-game transition.
- Undefined: the port and counter logic are absent; all other behaviour is identical.

Test Plan:
- Come-out natural: reset, dice_in=3,4, pulse roll_btn -> disp_en high exactly 8 cycles, dice1=3, dice2=4, win=1 two cycles after ROLL ends, point=0.
- Come-out craps: dice_in=6,6 -> lose=1, point=0. Then dice_in=1,1 with a new press -> game restarts, lose=0 at ROLL entry, ends with lose=1.
- Point made: dice_in=2,2 -> point=4, win=0, lose=0. Next roll dice_in=5,3 -> stays in POINT, point=4. Next roll dice_in=3,1 -> win=1. With ROLL_COUNT_EN, roll_count=3.
- Seven-out: dice_in=4,2 -> point=6. Next roll dice_in=3,4 -> lose=1, point stays 6.
- Invalid die and ignored press:
  - dice_in=0,5 at the last ROLL cycle, valid 1,5 three cycles later -> disp_en stays high 8+3 cycles, dice1=1, dice2=5 -> point=6.
  - roll_btn toggled during ROLL -> no extra roll.
- Reset mid-roll and held button: resetn low in ROLL cycle 4 -> disp_en, dice1, dice2, point, win and lose all 0 immediately. roll_btn held high across reset release -> no roll until it falls and rises again.
